// File: rtl/step_lane_input.sv
// PS/2 key-code to four-lane arrow state with held levels, hit pulses and a timestamped event FIFO.
// Define STEP_LANE_RELEASE_EVT_EN to also queue release events when a held lane drops.
module step_lane_input #(
  parameter logic [7:0] LEFT_CODE  = 8'h6B,
  parameter logic [7:0] DOWN_CODE  = 8'h72,
  parameter logic [7:0] UP_CODE    = 8'h75,
  parameter logic [7:0] RIGHT_CODE = 8'h74,
  parameter int         TICK_DIV   = 1000,
  parameter int         TS_W       = 16,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            reset_n,
  input  logic [7:0]      keyCode,
  input  logic            press,
  input  logic            ts_clr,
  output logic [3:0]      lane_held,
  output logic [3:0]      lane_hit,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [1:0]      evt_lane,
  output logic            evt_rel,
  output logic [TS_W-1:0] evt_time,
  output logic            overflow,
  input  logic            ovf_clr
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    if (v[1]) r = 2'd1;
    else if (v[2]) r = 2'd2;
    else if (v[3]) r = 2'd3;
    return r;
  endfunction

  logic [7:0]       k_q;
  logic             p_q;
  logic [3:0]       cur;
  logic [3:0]       hit_nxt;
  logic [PRE_W-1:0] pre;
  logic [TS_W-1:0]  ts;

  logic [1:0]       mem_lane [FIFO_DEPTH];
  logic [TS_W-1:0]  mem_time [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free;
  logic [CNT_W-1:0] n_push;
  logic             pop;
  logic             want_hit, acc_hit, drop;
  logic             w0_en;
  logic [1:0]       w0_lane;

  // Input stage: register the decoder outputs once
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      k_q <= 8'h00;
      p_q <= 1'b0;
    end else begin
      k_q <= keyCode;
      p_q <= press;
    end
  end

  always_comb begin
    cur = 4'b0000;
    if (p_q) begin
      if (k_q == LEFT_CODE)       cur = 4'b0001;
      else if (k_q == DOWN_CODE)  cur = 4'b0010;
      else if (k_q == UP_CODE)    cur = 4'b0100;
      else if (k_q == RIGHT_CODE) cur = 4'b1000;
    end
  end

  assign hit_nxt = cur & ~lane_held;

  // Lane stage: held level and rising-edge pulse
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_held <= 4'b0000;
      lane_hit  <= 4'b0000;
    end else begin
      lane_held <= cur;
      lane_hit  <= hit_nxt;
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
      ts  <= '0;
    end else if (ts_clr) begin
      pre <= '0;
      ts  <= '0;
    end else if (pre == PRE_W'(TICK_DIV - 1)) begin
      pre <= '0;
      ts  <= ts + TS_W'(1);
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  assign evt_valid = (count != '0);
  assign pop       = evt_valid & evt_ready;
  assign free      = CNT_W'(FIFO_DEPTH) - count + CNT_W'(pop);
  assign want_hit  = |hit_nxt;

`ifdef STEP_LANE_RELEASE_EVT_EN
  logic             mem_rel [FIFO_DEPTH];
  logic [3:0]       rel_nxt;
  logic             want_rel, acc_rel, w0_rel, w1_en;
  logic [PTR_W-1:0] w1_ptr;

  assign rel_nxt  = lane_held & ~cur;
  assign want_rel = |rel_nxt;

  // Release goes first; the hit only survives if a second slot remains
  always_comb begin
    acc_rel = want_rel && (free != '0);
    acc_hit = want_hit && (free > CNT_W'(acc_rel));
    drop    = (want_rel && !acc_rel) || (want_hit && !acc_hit);
    w0_en   = acc_rel | acc_hit;
    w0_rel  = acc_rel;
    w0_lane = acc_rel ? enc(rel_nxt) : enc(hit_nxt);
    w1_en   = acc_rel & acc_hit;
    w1_ptr  = wr_ptr + PTR_W'(1);
    n_push  = CNT_W'(w0_en) + CNT_W'(w1_en);
  end

  assign evt_rel = evt_valid ? mem_rel[rd_ptr] : 1'b0;
`else
  always_comb begin
    acc_hit = want_hit && (free != '0);
    drop    = want_hit && !acc_hit;
    w0_en   = acc_hit;
    w0_lane = enc(hit_nxt);
    n_push  = CNT_W'(w0_en);
  end

  assign evt_rel = 1'b0;
`endif

  // FIFO stage: up to two pushes and one pop per edge
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_lane[i] <= 2'd0;
        mem_time[i] <= '0;
`ifdef STEP_LANE_RELEASE_EVT_EN
        mem_rel[i]  <= 1'b0;
`endif
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (w0_en) begin
        mem_lane[wr_ptr] <= w0_lane;
        mem_time[wr_ptr] <= ts;
`ifdef STEP_LANE_RELEASE_EVT_EN
        mem_rel[wr_ptr]  <= w0_rel;
`endif
      end
`ifdef STEP_LANE_RELEASE_EVT_EN
      if (w1_en) begin
        mem_lane[w1_ptr] <= enc(hit_nxt);
        mem_time[w1_ptr] <= ts;
        mem_rel[w1_ptr]  <= 1'b0;
      end
`endif
      wr_ptr <= wr_ptr + PTR_W'(n_push);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + n_push - CNT_W'(pop);
      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  assign evt_lane = evt_valid ? mem_lane[rd_ptr] : 2'd0;
  assign evt_time = evt_valid ? mem_time[rd_ptr] : '0;

endmodule
